// File: rtl/boreal_gate_engine_pkg.sv
// Shared constants and helpers for the policy gate engine: request magic,
// verdict reason codes and response word layout.
package boreal_gate_engine_pkg;

    localparam logic [15:0] GATE_MAGIC = 16'hB0AE;

    localparam logic [7:0] GATE_RSN_OK    = 8'h00;
    localparam logic [7:0] GATE_RSN_MAGIC = 8'h01;
    localparam logic [7:0] GATE_RSN_CSUM  = 8'h02;
    localparam logic [7:0] GATE_RSN_RANGE = 8'h03;
    localparam logic [7:0] GATE_RSN_MASK  = 8'h04;
    localparam logic [7:0] GATE_RSN_LEN   = 8'h05;

    localparam logic [2:0] GATE_RESP_VERDICT  = 3'd0;
    localparam logic [2:0] GATE_RESP_SNAP0    = 3'd1;
    localparam logic [2:0] GATE_RESP_SEQ      = 3'd2;
    localparam logic [2:0] GATE_RESP_GRANTCNT = 3'd3;
    localparam logic [2:0] GATE_RESP_DENYCNT  = 3'd4;
    localparam logic [2:0] GATE_RESP_WORDS    = 3'd5;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] verdict_word(input logic grant, input logic [7:0] reason);
        return {16'h0, reason, 7'h0, grant};
    endfunction

endpackage

// File: rtl/boreal_gate_check.sv
// Combinational priority evaluation of a snapshotted request: the first
// failing rule sets the reason, grant only when every rule passes.
module boreal_gate_check
    import boreal_gate_engine_pkg::*;
#(
    parameter int NUM_ACTIONS = 32,
    parameter int MAX_LEN     = 4096
) (
    input  logic [15:0] magic,
    input  logic [7:0]  action,
    input  logic [31:0] req_len,
    input  logic [31:0] csum,
    input  logic [31:0] acc,
    input  logic [31:0] policy_mask,
    output logic        grant,
    output logic [7:0]  reason
);

    localparam logic [8:0]  ACT_LIMIT = 9'(NUM_ACTIONS);
    localparam logic [31:0] LEN_LIMIT = 32'(MAX_LEN);

    always_comb begin
        reason = GATE_RSN_OK;
        if (magic != GATE_MAGIC) begin
            reason = GATE_RSN_MAGIC;
        end else if (acc != csum) begin
            reason = GATE_RSN_CSUM;
        end else if ({1'b0, action} >= ACT_LIMIT) begin
            reason = GATE_RSN_RANGE;
        end else if (!policy_mask[action[4:0]]) begin
            reason = GATE_RSN_MASK;
        end else if (req_len > LEN_LIMIT) begin
            reason = GATE_RSN_LEN;
        end
        grant = (reason == GATE_RSN_OK);
    end

endmodule

// File: rtl/boreal_gate_engine.sv
// Policy gate engine: snapshots a 16-word request, XOR-checks and validates it,
// then writes a 5-word verdict into the response mailbox and consumes the request.
module boreal_gate_engine
    import boreal_gate_engine_pkg::*;
#(
    parameter int NUM_ACTIONS = 32,
    parameter int MAX_LEN     = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         gate_en,
    input  logic [31:0]  policy_mask,
    input  logic         req_valid,
    input  logic [511:0] req_words,
    output logic         req_consume,
    input  logic         resp_valid,
    output logic         resp_we,
    output logic [2:0]   resp_widx,
    output logic [31:0]  resp_wdata,
    output logic         resp_valid_set,
    output logic         busy,
    output logic [31:0]  grant_count,
    output logic [31:0]  deny_count
);

    // state  | meaning
    // IDLE   | waiting for a request while the response mailbox is free
    // CHECK  | XOR-accumulating snapshot words 0..14, one per cycle
    // DECIDE | evaluating the verdict and updating the counters
    // WRITE  | emitting response words 0..4
    // DONE   | setting response valid and consuming the request
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_DECIDE = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]  state;
    logic [31:0] snap [16];
    logic [31:0] acc;
    logic [3:0]  idx;
    logic [2:0]  wcnt;
    logic [31:0] seq;
    logic        grant_q;
    logic [7:0]  reason_q;
    logic        chk_grant;
    logic [7:0]  chk_reason;
    logic        accept;
    logic [31:0] word_mux;

    assign accept = (state == ST_IDLE) && gate_en && req_valid && !resp_valid;

    boreal_gate_check #(
        .NUM_ACTIONS(NUM_ACTIONS),
        .MAX_LEN    (MAX_LEN)
    ) u_check (
        .magic      (snap[0][31:16]),
        .action     (snap[0][7:0]),
        .req_len    (snap[2]),
        .csum       (snap[15]),
        .acc        (acc),
        .policy_mask(policy_mask),
        .grant      (chk_grant),
        .reason     (chk_reason)
    );

    // The request is frozen at accept so later mailbox changes cannot leak in.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 16; i++) begin
                snap[i] <= req_words[32*i +: 32];
            end
        end
    end

    always_comb begin
        word_mux = verdict_word(grant_q, reason_q);
        case (wcnt)
            GATE_RESP_SNAP0:    word_mux = snap[0];
            GATE_RESP_SEQ:      word_mux = seq;
            GATE_RESP_GRANTCNT: word_mux = grant_count;
            GATE_RESP_DENYCNT:  word_mux = deny_count;
            default:            word_mux = verdict_word(grant_q, reason_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            acc            <= '0;
            idx            <= '0;
            wcnt           <= '0;
            seq            <= '0;
            grant_q        <= 1'b0;
            reason_q       <= GATE_RSN_OK;
            grant_count    <= '0;
            deny_count     <= '0;
            req_consume    <= 1'b0;
            resp_we        <= 1'b0;
            resp_widx      <= '0;
            resp_wdata     <= '0;
            resp_valid_set <= 1'b0;
            busy           <= 1'b0;
        end else begin
            req_consume    <= 1'b0;
            resp_we        <= 1'b0;
            resp_valid_set <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= ST_CHECK;
                        busy  <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    acc <= acc ^ snap[idx];
                    if (idx == 4'd14) begin
                        idx   <= '0;
                        state <= ST_DECIDE;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                ST_DECIDE: begin
                    grant_q  <= chk_grant;
                    reason_q <= chk_reason;
                    if (chk_grant) begin
                        grant_count <= sat_inc(grant_count);
                    end else begin
                        deny_count <= sat_inc(deny_count);
                    end
                    // Word 0 goes out on this edge; words 3/4 later read the updated counters.
                    resp_we    <= 1'b1;
                    resp_widx  <= GATE_RESP_VERDICT;
                    resp_wdata <= verdict_word(chk_grant, chk_reason);
                    wcnt       <= GATE_RESP_SNAP0;
                    state      <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (wcnt == GATE_RESP_WORDS) begin
                        resp_valid_set <= 1'b1;
                        req_consume    <= 1'b1;
                        state          <= ST_DONE;
                    end else begin
                        resp_we    <= 1'b1;
                        resp_widx  <= wcnt;
                        resp_wdata <= word_mux;
                        wcnt       <= wcnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    seq   <= seq + 32'd1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boreal_gate_engine.sv
// Self-checking bench for boreal_gate_engine: directed vector table, randomized
// requests against a behavioural model, and multi-cycle corner sequences.
module tb_boreal_gate_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         gate_en;
    logic [31:0]  policy_mask;
    logic         req_valid;
    logic [511:0] req_words;
    logic         req_consume;
    logic         resp_valid;
    logic         resp_we;
    logic [2:0]   resp_widx;
    logic [31:0]  resp_wdata;
    logic         resp_valid_set;
    logic         busy;
    logic [31:0]  grant_count;
    logic [31:0]  deny_count;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [31:0] m_gc = 0;
    logic [31:0] m_dc = 0;
    logic [31:0] m_seq = 0;

    always #5 clk = ~clk;

    boreal_gate_engine dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .gate_en       (gate_en),
        .policy_mask   (policy_mask),
        .req_valid     (req_valid),
        .req_words     (req_words),
        .req_consume   (req_consume),
        .resp_valid    (resp_valid),
        .resp_we       (resp_we),
        .resp_widx     (resp_widx),
        .resp_wdata    (resp_wdata),
        .resp_valid_set(resp_valid_set),
        .busy          (busy),
        .grant_count   (grant_count),
        .deny_count    (deny_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_reason(input logic [511:0] w, input logic [31:0] mask);
        logic [31:0] x;
        logic [31:0] w0;
        x = 0;
        for (int i = 0; i < 15; i++) x = x ^ w[32*i +: 32];
        w0 = w[31:0];
        if (w0[31:16] != 16'hB0AE) return 8'h01;
        if (x != w[511:480]) return 8'h02;
        if (int'(w0[7:0]) >= 32) return 8'h03;
        if (mask[w0[4:0]] == 1'b0) return 8'h04;
        if (w[95:64] > 32'd4096) return 8'h05;
        return 8'h00;
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFFFFFF) ? v : v + 1;
    endfunction

    function automatic logic [511:0] mk_req(input logic [31:0] w0, input logic [31:0] w2, input logic [31:0] w15);
        logic [511:0] r;
        r = '0;
        r[31:0] = w0;
        r[95:64] = w2;
        r[511:480] = w15;
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_gc = 0; m_dc = 0; m_seq = 0;
    endtask

    // One full transaction; abort_cyc > 0 plants a reset at that cycle instead.
    task automatic run_txn(input string tag, input logic [511:0] words, input logic [31:0] mask,
                           input bit scramble, input bit drop_en, input int abort_cyc);
        logic [31:0] got [5];
        logic [31:0] exp [5];
        logic [7:0]  rsn;
        int cyc, we_n, vs_cyc;
        rsn = ref_reason(words, mask);
        if (rsn == 8'h00) m_gc = sat(m_gc); else m_dc = sat(m_dc);
        exp[0] = {16'h0, rsn, 7'h0, (rsn == 8'h00)};
        exp[1] = words[31:0];
        exp[2] = m_seq;
        exp[3] = m_gc;
        exp[4] = m_dc;
        for (int i = 0; i < 5; i++) got[i] = 32'hDEADBEEF;
        @(negedge clk);
        req_words = words; policy_mask = mask; req_valid = 1'b1; gate_en = 1'b1; resp_valid = 1'b0;
        cyc = 0; we_n = 0; vs_cyc = -1;
        while (cyc < 40 && vs_cyc < 0) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (cyc == 1) chk({tag, " busy_at_accept"}, {31'h0, busy}, 32'h1);
            if (scramble && cyc == 3)
                for (int i = 0; i < 16; i++) req_words[32*i +: 32] = $urandom();
            if (drop_en && cyc == 5) gate_en = 1'b0;
            if (resp_we) begin
                if (resp_widx < 3'd5) got[resp_widx] = resp_wdata;
                we_n++;
            end
            if (resp_valid_set) begin
                vs_cyc = cyc;
                chk({tag, " consume_with_vset"}, {31'h0, req_consume}, 32'h1);
            end
            if (cyc == abort_cyc) begin
                rst_n = 1'b0;
                @(posedge clk); @(negedge clk);
                chk({tag, " rst_busy"}, {31'h0, busy}, 32'h0);
                chk({tag, " rst_pulses"}, {29'h0, resp_we, resp_valid_set, req_consume}, 32'h0);
                chk({tag, " rst_gc"}, grant_count, 32'h0);
                chk({tag, " rst_dc"}, deny_count, 32'h0);
                rst_n = 1'b1;
                req_valid = 1'b0;
                m_gc = 0; m_dc = 0; m_seq = 0;
                for (int k = 0; k < 30; k++) begin
                    @(posedge clk); @(negedge clk);
                    if (resp_valid_set || req_consume || resp_we) begin
                        chk({tag, " post_rst_pulse"}, {29'h0, resp_we, resp_valid_set, req_consume}, 32'h0);
                        break;
                    end
                end
                return;
            end
        end
        chk({tag, " vset_cycle"}, 32'(vs_cyc), 32'd22);
        chk({tag, " we_count"}, 32'(we_n), 32'd5);
        chk({tag, " w0_verdict"}, got[0], exp[0]);
        chk({tag, " w1_snap0"}, got[1], exp[1]);
        chk({tag, " w2_seq"}, got[2], exp[2]);
        chk({tag, " w3_gcnt"}, got[3], exp[3]);
        chk({tag, " w4_dcnt"}, got[4], exp[4]);
        m_seq = m_seq + 1;
        // Mailbox now holds a valid response; req_valid lingers one more cycle.
        resp_valid = 1'b1;
        gate_en = 1'b1;
        @(posedge clk); @(negedge clk);
        chk({tag, " no_reaccept"}, {29'h0, busy, resp_valid_set, req_consume}, 32'h0);
        chk({tag, " gc_out"}, grant_count, m_gc);
        chk({tag, " dc_out"}, deny_count, m_dc);
        req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        resp_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w2;
        logic [31:0] w15;
        logic [31:0] mask;
        logic [7:0]  exp_reason;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [511:0] r;
        logic [31:0]  x;
        int bad;

        vecs[0] = '{32'hB0AE0003, 32'h10,   32'hB0AE0013, 32'h8,        8'h00};
        vecs[1] = '{32'hB0AE0003, 32'h10,   32'h0,        32'h8,        8'h02};
        vecs[2] = '{32'h12340003, 32'h10,   32'h12340013, 32'h8,        8'h01};
        vecs[3] = '{32'hB0AE0005, 32'h10,   32'hB0AE0015, 32'h8,        8'h04};
        vecs[4] = '{32'hB0AE0020, 32'h0,    32'hB0AE0020, 32'hFFFFFFFF, 8'h03};
        vecs[5] = '{32'hB0AE0001, 32'h1001, 32'hB0AE1000, 32'h2,        8'h05};
        vecs[6] = '{32'hB0AE0001, 32'h1000, 32'hB0AE1001, 32'h2,        8'h00};
        vecs[7] = '{32'hB0AE001F, 32'h0,    32'hB0AE001F, 32'h80000000, 8'h00};
        vecs[8] = '{32'hB0AE0023, 32'h0,    32'hB0AE0023, 32'h8,        8'h03};

        gate_en = 1'b0; policy_mask = '0; req_valid = 1'b0; req_words = '0; resp_valid = 1'b0;
        do_reset();
        chk("reset_outputs", {26'h0, busy, resp_we, resp_valid_set, req_consume, 2'b0}, 32'h0);
        chk("reset_widx_wdata", {29'h0, resp_widx} | resp_wdata, 32'h0);
        chk("reset_gc", grant_count, 32'h0);
        chk("reset_dc", deny_count, 32'h0);

        foreach (vecs[i]) begin
            r = mk_req(vecs[i].w0, vecs[i].w2, vecs[i].w15);
            chk($sformatf("vec%0d model_reason", i), {24'h0, ref_reason(r, vecs[i].mask)}, {24'h0, vecs[i].exp_reason});
            run_txn($sformatf("vec%0d", i), r, vecs[i].mask, 1'b0, 1'b0, 0);
        end

        // Backpressure: unacked response blocks accept.
        @(negedge clk);
        req_words = mk_req(32'hB0AE0003, 32'h10, 32'hB0AE0013);
        policy_mask = 32'h8; gate_en = 1'b1; req_valid = 1'b1; resp_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); @(negedge clk);
            if (busy || resp_we) bad++;
        end
        chk("backpressure_idle", 32'(bad), 32'h0);
        run_txn("bp_release", mk_req(32'hB0AE0003, 32'h10, 32'hB0AE0013), 32'h8, 1'b0, 1'b0, 0);

        // gate_en low blocks accept.
        @(negedge clk);
        gate_en = 1'b0; req_valid = 1'b1; resp_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); @(negedge clk);
            if (busy || resp_we) bad++;
        end
        chk("gate_disabled_idle", 32'(bad), 32'h0);
        req_valid = 1'b0;

        // Randomized requests, with mid-transaction scrambling and gate_en drops.
        for (int n = 0; n < 25; n++) begin
            r = '0;
            for (int i = 1; i < 15; i++) r[32*i +: 32] = $urandom();
            if ($urandom_range(0, 1) == 0) r[95:64] = 32'($urandom_range(0, 5000));
            r[31:16] = ($urandom_range(0, 7) == 0) ? 16'($urandom()) : 16'hB0AE;
            r[15:8]  = 8'($urandom());
            r[7:0]   = 8'($urandom_range(0, 40));
            x = 0;
            for (int i = 0; i < 15; i++) x = x ^ r[32*i +: 32];
            r[511:480] = ($urandom_range(0, 7) == 0) ? $urandom() : x;
            run_txn($sformatf("rnd%0d", n), r,
                    ($urandom_range(0, 2) == 0) ? 32'hFFFFFFFF : $urandom(),
                    1'b1, ($urandom_range(0, 1) == 1), 0);
        end

        // Reset during WRITE discards the transaction and clears counters and seq.
        run_txn("rst_mid", mk_req(32'hB0AE0003, 32'h10, 32'hB0AE0013), 32'h8, 1'b0, 1'b0, 18);
        run_txn("after_rst", mk_req(32'hB0AE0003, 32'h10, 32'h0), 32'h8, 1'b0, 1'b0, 0);

        // Saturation of grant_count.
        @(negedge clk);
        force dut.grant_count = 32'hFFFFFFFF;
        @(posedge clk); @(negedge clk);
        release dut.grant_count;
        @(posedge clk); @(negedge clk);
        chk("sat_preload", grant_count, 32'hFFFFFFFF);
        m_gc = 32'hFFFFFFFF;
        run_txn("sat", mk_req(32'hB0AE0003, 32'h10, 32'hB0AE0013), 32'h8, 1'b0, 1'b0, 0);
        chk("sat_hold", grant_count, 32'hFFFFFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
